// File: rtl/uart_rx_apb_ctrl.sv
// APB3 register front-end for uart_rx: byte FIFO, status/control/overrun-count registers.
// Optional interrupt output is enabled by defining UART_RX_APB_CTRL_IRQ_EN.
module uart_rx_apb_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq,
  output logic [7:0]        last_byte
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              rx_en, irq_en, overrun;
  logic [7:0]        ovr_cnt;

  logic              access, empty, full;
  logic [ADDR_W-3:0] reg_idx;
  logic              is_data, is_status, is_ctrl, is_ovr, mapped, bus_err;
  logic              pop, push, drop, flush, clear_ovr, wr_ctrl, rx_acc;
  logic              unused_bits;

  assign access    = psel & penable;
  assign reg_idx   = paddr[ADDR_W-1:2];
  assign is_data   = (reg_idx == (ADDR_W-2)'(0));
  assign is_status = (reg_idx == (ADDR_W-2)'(1));
  assign is_ctrl   = (reg_idx == (ADDR_W-2)'(2));
  assign is_ovr    = (reg_idx == (ADDR_W-2)'(3));
  assign mapped    = is_data | is_status | is_ctrl | is_ovr;
  assign bus_err   = access & (!mapped | (pwrite & (is_data | is_ovr)));

  assign empty     = (level == '0);
  assign full      = (level == LVL_W'(FIFO_DEPTH));

  assign pop       = access & !pwrite & is_data & !empty;
  assign wr_ctrl   = access & pwrite & is_ctrl;
  assign flush     = wr_ctrl & pwdata[1];
  assign clear_ovr = access & pwrite & is_status & pwdata[2];
  assign rx_acc    = rx_valid & rx_en;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push      = rx_acc & (!full | pop) & !flush;
  assign drop      = rx_acc & full & !pop & !flush;

  assign pready      = 1'b1;
  assign pslverr     = bus_err;
  assign unused_bits = ^{pwdata[31:3], paddr[1:0]};

  always_comb begin
    prdata = '0;
    if (access && !pwrite && !bus_err) begin
      if (is_data && !empty) begin
        prdata[8]   = 1'b1;
        prdata[7:0] = mem[rd_ptr];
      end
      if (is_status) begin
        prdata[0]            = empty;
        prdata[1]            = full;
        prdata[2]            = overrun;
        prdata[8 +: LVL_W]   = level;
      end
      if (is_ctrl) begin
        prdata[0] = rx_en;
        prdata[2] = irq_en;
      end
      if (is_ovr) prdata[7:0] = ovr_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rx_en     <= 1'b1;
      overrun   <= 1'b0;
      ovr_cnt   <= '0;
      last_byte <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        level <= level + LVL_W'(push) - LVL_W'(pop);
      end
      if (wr_ctrl) rx_en <= pwdata[0];
      if (rx_acc)  last_byte <= rx_data;
      // A drop on the same edge as the W1C wins and restarts the count at 1.
      if (drop) begin
        overrun <= 1'b1;
        if (clear_ovr)            ovr_cnt <= 8'd1;
        else if (ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
      end else if (clear_ovr) begin
        overrun <= 1'b0;
        ovr_cnt <= '0;
      end
    end
  end

`ifdef UART_RX_APB_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= pwdata[2];
      irq <= irq_en & (!empty | overrun);
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_apb_ctrl.sv
// Self-checking bench for uart_rx_apb_ctrl: scoreboard queue of expected DATA reads.
module tb_uart_rx_apb_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr, irq;
  logic [7:0]  last_byte;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q [$];
  logic [31:0] rd;
  logic        err;

  uart_rx_apb_ctrl #(.FIFO_DEPTH(8), .ADDR_W(5)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .irq(irq), .last_byte(last_byte)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer; optionally strobes rx_valid on the edge that ends the access phase.
  task automatic apb_access(input logic [4:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic rxv, input logic [7:0] rxb,
                            output logic [31:0] data, output logic perr);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
    @(negedge clk);
    penable = 1'b1; rx_valid = rxv; rx_data = rxb;
    #1 data = prdata; perr = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic apb_write(input logic [4:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    logic        e;
    apb_access(addr, 1'b1, wdata, 1'b0, 8'h00, d, e);
  endtask

  task automatic apb_read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_access(addr, 1'b0, 32'h0, 1'b0, 8'h00, d, e);
    check_output(tag, d, exp);
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic sb_read_data(input string tag);
    logic [31:0] d;
    logic        e;
    logic [31:0] exp;
    exp = (exp_q.size() > 0) ? {23'b0, 1'b1, exp_q.pop_front()} : 32'h0;
    apb_access(5'h00, 1'b0, 32'h0, 1'b0, 8'h00, d, e);
    check_output(tag, d, exp);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0;
    psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Reset state
    check_output("idle_prdata", prdata, 32'h0);
    check_output("idle_pslverr", {31'b0, pslverr}, 32'h0);
    check_output("rst_irq", {31'b0, irq}, 32'h0);
    check_output("rst_last", {24'b0, last_byte}, 32'h0);
    apb_read_check("rst_status", 5'h04, 32'h0000_0001);
    apb_read_check("rst_ctrl", 5'h08, 32'h1);
    apb_read_check("rst_ovr", 5'h0C, 32'h0);

    // Basic receive and drain
    apply_stimulus(8'hA5); exp_q.push_back(8'hA5);
    apply_stimulus(8'h3C); exp_q.push_back(8'h3C);
    sb_read_data("data0");
    sb_read_data("data1");
    sb_read_data("data_empty");
    check_output("last_3c", {24'b0, last_byte}, 32'h3C);

    // Overflow: 10 bytes into 8 slots
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(8'h10 + 8'(i));
      if (i < 8) exp_q.push_back(8'h10 + 8'(i));
    end
    apb_read_check("ovf_status", 5'h04, 32'h0000_0806);
    apb_read_check("ovf_cnt", 5'h0C, 32'h2);
    apb_write(5'h04, 32'h4);
    apb_read_check("w1c_status", 5'h04, 32'h0000_0802);
    apb_read_check("w1c_cnt", 5'h0C, 32'h0);

    // Push and pop on the same edge while full
    apb_access(5'h00, 1'b0, 32'h0, 1'b1, 8'h77, rd, err);
    check_output("pushpop_data", rd, {23'b0, 1'b1, exp_q.pop_front()});
    exp_q.push_back(8'h77);
    apb_read_check("pushpop_status", 5'h04, 32'h0000_0802);
    for (int i = 0; i < 8; i++) sb_read_data("drain");
    sb_read_data("drain_empty");

    // Receive disabled
    apb_write(5'h08, 32'h0);
    apply_stimulus(8'h55);
    apb_read_check("dis_status", 5'h04, 32'h0000_0001);
    check_output("dis_last", {24'b0, last_byte}, 32'h77);
    apb_read_check("dis_cnt", 5'h0C, 32'h0);

    // Flush with bytes queued
    apb_write(5'h08, 32'h1);
    for (int i = 0; i < 3; i++) apply_stimulus(8'hC0 + 8'(i));
    apb_read_check("pre_flush", 5'h04, 32'h0000_0300);
    apb_write(5'h08, 32'h3);
    apb_read_check("flush_status", 5'h04, 32'h0000_0001);
    apb_read_check("flush_ctrl", 5'h08, 32'h1);

    // Flush and push on the same edge
    apb_access(5'h08, 1'b1, 32'h3, 1'b1, 8'h99, rd, err);
    apb_read_check("flushpush_status", 5'h04, 32'h0000_0001);
    check_output("flushpush_last", {24'b0, last_byte}, 32'h99);

    // W1C racing a new overrun: set wins
    for (int i = 0; i < 9; i++) apply_stimulus(8'h40 + 8'(i));
    apb_access(5'h04, 1'b1, 32'h4, 1'b1, 8'hAB, rd, err);
    apb_read_check("race_status", 5'h04, 32'h0000_0806);
    apb_read_check("race_cnt", 5'h0C, 32'h1);
    apb_write(5'h08, 32'h3);
    apb_read_check("flush_keeps_ovr", 5'h04, 32'h0000_0005);
    apb_read_check("flush_keeps_cnt", 5'h0C, 32'h1);
    apb_write(5'h04, 32'h4);

    // Bus errors
    apb_access(5'h00, 1'b1, 32'hFF, 1'b0, 8'h00, rd, err);
    check_output("err_wr_data", {31'b0, err}, 32'h1);
    apb_access(5'h0C, 1'b1, 32'hFF, 1'b0, 8'h00, rd, err);
    check_output("err_wr_ovr", {31'b0, err}, 32'h1);
    apb_access(5'h10, 1'b0, 32'h0, 1'b0, 8'h00, rd, err);
    check_output("err_rd_unmap", {31'b0, err}, 32'h1);
    check_output("err_rd_prdata", rd, 32'h0);
    apb_access(5'h18, 1'b1, 32'h2, 1'b0, 8'h00, rd, err);
    check_output("err_wr_unmap", {31'b0, err}, 32'h1);
    apb_access(5'h04, 1'b0, 32'h0, 1'b0, 8'h00, rd, err);
    check_output("ok_pslverr", {31'b0, err}, 32'h0);
    check_output("ok_status", rd, 32'h0000_0001);
    apb_read_check("err_ctrl_kept", 5'h08, 32'h1);

    // Interrupt
    apb_write(5'h08, 32'h5);
`ifdef UART_RX_APB_CTRL_IRQ_EN
    apb_read_check("irq_ctrl", 5'h08, 32'h5);
    apply_stimulus(8'h66); exp_q.push_back(8'h66);
    repeat (2) @(negedge clk);
    check_output("irq_set", {31'b0, irq}, 32'h1);
    sb_read_data("irq_pop");
    repeat (2) @(negedge clk);
    check_output("irq_clr", {31'b0, irq}, 32'h0);
`else
    apb_read_check("irq_ctrl", 5'h08, 32'h1);
    apply_stimulus(8'h66); exp_q.push_back(8'h66);
    repeat (2) @(negedge clk);
    check_output("irq_tied", {31'b0, irq}, 32'h0);
    sb_read_data("irq_pop");
`endif

    // Reset in the middle of activity
    apply_stimulus(8'h12);
    apply_stimulus(8'h34);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    apb_read_check("mid_rst_status", 5'h04, 32'h0000_0001);
    apb_read_check("mid_rst_ctrl", 5'h08, 32'h1);
    check_output("mid_rst_last", {24'b0, last_byte}, 32'h0);
    check_output("mid_rst_irq", {31'b0, irq}, 32'h0);
    check_output("pready", {31'b0, pready}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
